// File: rtl/sprite_pkg.sv
// Shared sprite descriptor definitions.
// Used by the sprite packer and by the sprite field splitter, so both sides
// agree on the descriptor layout: {en, offset[4:0], line[3:0], num[4:0]}.
// Contents: field widths, field bit positions, the 15-bit descriptor type and
// the packer FSM state type.
package sprite_pkg;

  localparam int unsigned NUM_W      = 5;
  localparam int unsigned LINE_W     = 4;
  localparam int unsigned OFFSET_W   = 5;

  localparam int unsigned NUM_LSB    = 0;
  localparam int unsigned LINE_LSB   = 5;
  localparam int unsigned OFFSET_LSB = 9;
  localparam int unsigned EN_BIT     = 14;

  typedef logic [14:0] sprite_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRTY  = 2'd1,
    ST_COMMIT = 2'd2
  } packer_state_t;

endpackage

// File: rtl/sprite_packer_if.sv
// Field-write port of the sprite packer.
// master: the host / game-logic side driving field writes.
// slave : the packer, which returns wr_ready.
// Signals: wr_valid, wr_ready, wr_slot[1:0], wr_num[4:0], wr_line[3:0],
//          wr_offset[4:0], wr_en. A write is accepted when wr_valid && wr_ready.
interface sprite_packer_if;
  import sprite_pkg::*;

  logic                wr_valid;
  logic                wr_ready;
  logic [1:0]          wr_slot;
  logic [NUM_W-1:0]    wr_num;
  logic [LINE_W-1:0]   wr_line;
  logic [OFFSET_W-1:0] wr_offset;
  logic                wr_en;

  modport master (
    output wr_valid, wr_slot, wr_num, wr_line, wr_offset, wr_en,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_slot, wr_num, wr_line, wr_offset, wr_en,
    output wr_ready
  );

endinterface

// File: rtl/sprite_field_pack.sv
// Combinational packer: assembles a sprite descriptor from its fields using
// the shared layout constants.
// Ports: num_i, line_i, offset_i, en_i (fields in), desc_o (packed descriptor).
module sprite_field_pack
  import sprite_pkg::*;
(
  input  logic [NUM_W-1:0]    num_i,
  input  logic [LINE_W-1:0]   line_i,
  input  logic [OFFSET_W-1:0] offset_i,
  input  logic                en_i,
  output sprite_desc_t        desc_o
);

  always_comb begin
    desc_o                           = '0;
    desc_o[NUM_LSB    +: NUM_W]      = num_i;
    desc_o[LINE_LSB   +: LINE_W]     = line_i;
    desc_o[OFFSET_LSB +: OFFSET_W]   = offset_i;
    desc_o[EN_BIT]                   = en_i;
  end

endmodule

// File: rtl/sprite_packer.sv
// sprite_packer: collects per-slot field writes into four shadow descriptors
// and copies all of them to the active outputs in one edge at the next frame
// boundary, so a renderer never observes a half-updated sprite.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr                  field-write port (sprite_packer_if.slave)
//   frame_start         one-cycle frame boundary pulse
//   line_strobe         line-advance pulse (only with SPRITE_PACKER_AUTOLINE_EN)
//   sprite0..sprite3    active descriptors (registered)
//   pending             shadow holds writes not yet committed
//   commit_done         one-cycle pulse while freshly committed values are visible
// Optional feature macro: SPRITE_PACKER_AUTOLINE_EN -- each line_strobe advances
// the line field (mod 16) of every enabled active descriptor.
module sprite_packer
  import sprite_pkg::*;
#(
  parameter int unsigned         DESC_W     = 15,
  parameter logic [DESC_W-1:0]   RESET_DESC = 15'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  sprite_packer_if.slave    wr,
  input  logic              frame_start,
`ifdef SPRITE_PACKER_AUTOLINE_EN
  input  logic              line_strobe,
`endif
  output logic [DESC_W-1:0] sprite0,
  output logic [DESC_W-1:0] sprite1,
  output logic [DESC_W-1:0] sprite2,
  output logic [DESC_W-1:0] sprite3,
  output logic              pending,
  output logic              commit_done
);

  packer_state_t state_q, state_d;
  sprite_desc_t  shadow_q [4];
  sprite_desc_t  active_q [4];
  logic          commit_done_q;
  sprite_desc_t  wr_desc;
  logic          wr_accept;

  sprite_field_pack u_field_pack (
    .num_i    (wr.wr_num),
    .line_i   (wr.wr_line),
    .offset_i (wr.wr_offset),
    .en_i     (wr.wr_en),
    .desc_o   (wr_desc)
  );

  // Next state and state-decoded outputs; wr_ready depends on state only.
  always_comb begin
    state_d     = state_q;
    wr.wr_ready = 1'b1;
    pending     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A frame_start arriving with the first write does not commit it.
        if (wr.wr_valid) state_d = ST_DIRTY;
      end
      ST_DIRTY: begin
        pending = 1'b1;
        if (frame_start) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        wr.wr_ready = 1'b0;
        pending     = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_accept = wr.wr_valid && wr.wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      commit_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      commit_done_q <= (state_q == ST_COMMIT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) shadow_q[i] <= RESET_DESC;
    end else if (wr_accept) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr.wr_slot == 2'(i)) shadow_q[i] <= wr_desc;
      end
    end
  end

  // Commit takes precedence over a same-edge line advance, so the freshly
  // loaded shadow line value is never incremented on the commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) active_q[i] <= RESET_DESC;
    end else if (state_q == ST_COMMIT) begin
      for (int unsigned i = 0; i < 4; i++) active_q[i] <= shadow_q[i];
    end
`ifdef SPRITE_PACKER_AUTOLINE_EN
    else if (line_strobe) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (active_q[i][EN_BIT]) begin
          active_q[i][LINE_LSB +: LINE_W] <= active_q[i][LINE_LSB +: LINE_W] + 1'b1;
        end
      end
    end
`endif
  end

  assign sprite0     = active_q[0];
  assign sprite1     = active_q[1];
  assign sprite2     = active_q[2];
  assign sprite3     = active_q[3];
  assign commit_done = commit_done_q;

endmodule

// File: tb/tb_sprite_packer.sv
module tb_sprite_packer;
  import sprite_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
`ifdef SPRITE_PACKER_AUTOLINE_EN
  logic line_strobe = 1'b0;
`endif
  logic [14:0] sprite0, sprite1, sprite2, sprite3;
  logic        pending, commit_done;
  logic [14:0] act [4];

  always #5 clk = ~clk;

  sprite_packer_if wif ();

  sprite_packer #(.DESC_W(15), .RESET_DESC(15'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr          (wif.slave),
    .frame_start (frame_start),
`ifdef SPRITE_PACKER_AUTOLINE_EN
    .line_strobe (line_strobe),
`endif
    .sprite0     (sprite0),
    .sprite1     (sprite1),
    .sprite2     (sprite2),
    .sprite3     (sprite3),
    .pending     (pending),
    .commit_done (commit_done)
  );

  assign act[0] = sprite0;
  assign act[1] = sprite1;
  assign act[2] = sprite2;
  assign act[3] = sprite3;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: what the host has written but not yet shown, what is
  // on screen, and whether a frame boundary has scheduled a copy.
  logic [14:0] m_shadow [4];
  logic [14:0] m_active [4];
  bit          m_dirty, m_commit, m_done;

  function automatic logic [14:0] pack(input int num, input int line, input int off, input int en);
    return 15'(en * 16384 + off * 512 + line * 32 + num);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 4; s++) begin
      m_shadow[s] = 15'h0000;
      m_active[s] = 15'h0000;
    end
    m_dirty = 0; m_commit = 0; m_done = 0;
  endfunction

  task automatic cycle(input bit v, input int slot, input int num, input int line,
                       input int off, input int en, input bit fs, input bit ls);
    bit accept;
    int ln;
    wif.wr_valid  = v;
    wif.wr_slot   = 2'(slot);
    wif.wr_num    = 5'(num);
    wif.wr_line   = 4'(line);
    wif.wr_offset = 5'(off);
    wif.wr_en     = 1'(en);
    frame_start   = fs;
`ifdef SPRITE_PACKER_AUTOLINE_EN
    line_strobe   = ls;
`endif
    @(posedge clk);
    accept = v && !m_commit;
    if (m_commit) begin
      for (int s = 0; s < 4; s++) m_active[s] = m_shadow[s];
      m_commit = 0; m_dirty = 0; m_done = 1;
    end else begin
      m_done = 0;
`ifdef SPRITE_PACKER_AUTOLINE_EN
      if (ls) begin
        for (int s = 0; s < 4; s++) begin
          if (m_active[s] >= 15'd16384) begin
            ln = (int'(m_active[s]) / 32) % 16;
            m_active[s] = 15'(int'(m_active[s]) - ln * 32 + ((ln + 1) % 16) * 32);
          end
        end
      end
`endif
      if (fs && m_dirty) m_commit = 1;
      if (accept) begin
        m_shadow[slot] = pack(num, line, off, en);
        m_dirty = 1;
      end
    end
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wif.wr_valid = 0; wif.wr_slot = 0; wif.wr_num = 0; wif.wr_line = 0;
    wif.wr_offset = 0; wif.wr_en = 0; frame_start = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    for (int s = 0; s < 4; s++) begin
      vectors++;
      if (act[s] !== 15'h0000) begin
        miscompares++; $display("FAIL reset_sprite%0d got %h want 0000", s, act[s]);
      end
    end
    vectors++;
    if (pending !== 1'b0) begin miscompares++; $display("FAIL reset_pending got %b want 0", pending); end
    vectors++;
    if (wif.wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_wr_ready got %b want 1", wif.wr_ready); end
    vectors++;
    if (commit_done !== 1'b0) begin miscompares++; $display("FAIL reset_commit_done got %b want 0", commit_done); end
  endtask

  task automatic test_single_commit();
    cycle(1, 2, 'h13, 7, 'h0A, 1, 0, 0);
    vectors++;
    if (pending !== 1'b1) begin miscompares++; $display("FAIL single_pending got %b want 1", pending); end
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    vectors++;
    if (wif.wr_ready !== 1'b0) begin miscompares++; $display("FAIL single_ready_commit got %b want 0", wif.wr_ready); end
    vectors++;
    if (sprite2 !== 15'h0000) begin miscompares++; $display("FAIL single_early got %h want 0000", sprite2); end
    idle();
    vectors++;
    if (sprite2 !== 15'h54F3) begin miscompares++; $display("FAIL single_sprite2 got %h want 54f3", sprite2); end
    vectors++;
    if (commit_done !== 1'b1) begin miscompares++; $display("FAIL single_done got %b want 1", commit_done); end
    vectors++;
    if ({sprite0, sprite1, sprite3} !== 45'h0) begin
      miscompares++; $display("FAIL single_others got %h %h %h want 0", sprite0, sprite1, sprite3);
    end
    vectors++;
    if (pending !== 1'b0) begin miscompares++; $display("FAIL single_pending_after got %b want 0", pending); end
    idle();
    vectors++;
    if (commit_done !== 1'b0) begin miscompares++; $display("FAIL single_done_pulse got %b want 0", commit_done); end
  endtask

  task automatic test_write_with_frame_idle();
    cycle(1, 0, 3, 0, 0, 0, 1, 0);
    idle();
    vectors++;
    if (commit_done !== 1'b0 || sprite0 !== 15'h0000) begin
      miscompares++; $display("FAIL idle_frame_nocommit got done=%b s0=%h want 0/0000", commit_done, sprite0);
    end
    vectors++;
    if (pending !== 1'b1) begin miscompares++; $display("FAIL idle_frame_pending got %b want 1", pending); end
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    vectors++;
    if (sprite0 !== 15'h0003 || commit_done !== 1'b1) begin
      miscompares++; $display("FAIL idle_frame_commit got s0=%h done=%b want 0003/1", sprite0, commit_done);
    end
  endtask

  task automatic test_overwrite_and_ready();
    cycle(1, 1, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 2, 0, 0, 0, 0, 0);
    vectors++;
    if (wif.wr_ready !== 1'b1) begin miscompares++; $display("FAIL ovr_ready_dirty got %b want 1", wif.wr_ready); end
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    vectors++;
    if (wif.wr_ready !== 1'b0) begin miscompares++; $display("FAIL ovr_ready_commit got %b want 0", wif.wr_ready); end
    // write offered during COMMIT must be refused
    cycle(1, 1, 9, 0, 0, 0, 0, 0);
    vectors++;
    if (sprite1 !== 15'h0002) begin miscompares++; $display("FAIL ovr_sprite1 got %h want 0002", sprite1); end
    vectors++;
    if (wif.wr_ready !== 1'b1 || pending !== 1'b0) begin
      miscompares++; $display("FAIL ovr_after got ready=%b pending=%b want 1/0", wif.wr_ready, pending);
    end
  endtask

  task automatic test_reset_during_commit();
    cycle(1, 3, 31, 15, 31, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 4; s++) begin
      vectors++;
      if (act[s] !== 15'h0000) begin
        miscompares++; $display("FAIL rstc_sprite%0d got %h want 0000", s, act[s]);
      end
    end
    vectors++;
    if (pending !== 1'b0 || commit_done !== 1'b0 || wif.wr_ready !== 1'b1) begin
      miscompares++; $display("FAIL rstc_flags got p=%b d=%b r=%b want 0/0/1", pending, commit_done, wif.wr_ready);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();
    vectors++;
    if (sprite3 !== 15'h0000 || commit_done !== 1'b0 || pending !== 1'b0) begin
      miscompares++; $display("FAIL rstc_lost got s3=%h d=%b p=%b want 0000/0/0", sprite3, commit_done, pending);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), int'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0), bit'($urandom_range(0, 1)));
      for (int s = 0; s < 4; s++) begin
        vectors++;
        if (act[s] !== m_active[s]) begin
          miscompares++; $display("FAIL rand_sprite%0d n=%0d got %h want %h", s, n, act[s], m_active[s]);
        end
      end
      vectors++;
      if (pending !== (m_dirty || m_commit)) begin
        miscompares++; $display("FAIL rand_pending n=%0d got %b want %b", n, pending, m_dirty || m_commit);
      end
      vectors++;
      if (wif.wr_ready !== !m_commit) begin
        miscompares++; $display("FAIL rand_ready n=%0d got %b want %b", n, wif.wr_ready, !m_commit);
      end
      vectors++;
      if (commit_done !== m_done) begin
        miscompares++; $display("FAIL rand_done n=%0d got %b want %b", n, commit_done, m_done);
      end
    end
  endtask

`ifdef SPRITE_PACKER_AUTOLINE_EN
  task automatic test_autoline();
    idle();
    idle();
    cycle(1, 3, 4, 15, 1, 1, 0, 0);
    cycle(1, 0, 6, 4, 2, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    vectors++;
    if (sprite3 !== pack(4, 15, 1, 1)) begin
      miscompares++; $display("FAIL auto_loaded got %h want %h", sprite3, pack(4, 15, 1, 1));
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    vectors++;
    if (sprite3 !== pack(4, 0, 1, 1)) begin
      miscompares++; $display("FAIL auto_wrap got %h want %h", sprite3, pack(4, 0, 1, 1));
    end
    vectors++;
    if (sprite0 !== pack(6, 4, 2, 0)) begin
      miscompares++; $display("FAIL auto_disabled got %h want %h", sprite0, pack(6, 4, 2, 0));
    end
    cycle(1, 3, 4, 9, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    vectors++;
    if (sprite3 !== pack(4, 9, 1, 1)) begin
      miscompares++; $display("FAIL auto_commit_wins got %h want %h", sprite3, pack(4, 9, 1, 1));
    end
    for (int s = 0; s < 4; s++) begin
      vectors++;
      if (act[s] !== m_active[s]) begin
        miscompares++; $display("FAIL auto_model_sprite%0d got %h want %h", s, act[s], m_active[s]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_commit();
    test_write_with_frame_idle();
    test_overwrite_and_ready();
    test_reset_during_commit();
    test_random();
`ifdef SPRITE_PACKER_AUTOLINE_EN
    test_autoline();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
